argmax_8_16: RTL and testbench

ARGMAX_8_16 -- requirements
Module: argmax_8_16

---
 rtl/argmax_8_16_pkg.sv | 15 +
 rtl/argmax_8_16_if.sv | 25 ++
 rtl/argmax_8_16.sv | 91 +++++++++
 tb/tb_argmax_8_16.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/argmax_8_16_pkg.sv
// Shared constants and types for the streaming argmax block.
package argmax_8_16_pkg;

  localparam int unsigned N  = 8;
  localparam int unsigned T  = 16;
  localparam int unsigned IW = $clog2(N);

  typedef logic signed [T-1:0] elem_t;

  typedef enum logic {
    COLLECT,
    OUTPUT
  } state_e;

endpackage

// File: rtl/argmax_8_16_if.sv
// Element stream in, argmax result out; slave is the block side, master the driver side.
interface argmax_8_16_if #(
  parameter int unsigned T  = argmax_8_16_pkg::T,
  parameter int unsigned IW = argmax_8_16_pkg::IW
);

  logic                 s_valid;
  logic                 s_ready;
  logic signed [T-1:0]  data_in;
  logic                 m_valid;
  logic                 m_ready;
  logic [IW-1:0]        idx_out;
  logic signed [T-1:0]  max_out;

  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, idx_out, max_out
  );

  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, idx_out, max_out
  );

endinterface

// File: rtl/argmax_8_16.sv
// Streaming argmax over N signed elements: collect a vector, then hold the
// winning index/value until the downstream handshake.
module argmax_8_16 #(
  parameter int unsigned N  = argmax_8_16_pkg::N,
  parameter int unsigned T  = argmax_8_16_pkg::T,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  argmax_8_16_if.slave    bus
);

  import argmax_8_16_pkg::*;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e               state_q;
  logic                 s_ready_q;
  logic                 m_valid_q;
  logic [IW-1:0]        cnt_q;
  logic [IW-1:0]        run_idx_q;
  logic [IW-1:0]        run_idx_d;
  logic [IW-1:0]        idx_q;
  logic signed [T-1:0]  run_max_q;
  logic signed [T-1:0]  run_max_d;
  logic signed [T-1:0]  max_q;
  logic                 accept;
  logic                 last;

  // Element 0 always seeds the running max; later elements win only on strict >.
  always_comb begin
    accept    = bus.s_valid && s_ready_q;
    last      = (cnt_q == LAST_IDX);
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    if ((cnt_q == '0) || (bus.data_in > run_max_q)) begin
      run_max_d = bus.data_in;
      run_idx_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= COLLECT;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      cnt_q     <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      max_q     <= '0;
      idx_q     <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            if (last) begin
              cnt_q     <= '0;
              max_q     <= run_max_d;
              idx_q     <= run_idx_d;
              state_q   <= OUTPUT;
              s_ready_q <= 1'b0;
              m_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + IW'(1);
            end
          end
        end
        OUTPUT: begin
          if (bus.m_ready) begin
            state_q   <= COLLECT;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= COLLECT;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.idx_out = idx_q;
  assign bus.max_out = max_q;

endmodule

// File: tb/tb_argmax_8_16.sv
// Self-checking bench for argmax_8_16 against a vector-level reference model.
module tb_argmax_8_16;

  import argmax_8_16_pkg::*;

  logic clk;
  logic reset;

  argmax_8_16_if #(.T(T), .IW(IW)) bus ();

  argmax_8_16 #(.N(N), .T(T), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: buffered vector elements and the last delivered result.
  int q_elems[$];
  bit exp_pending = 0;
  int exp_idx     = 0;
  int exp_max     = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void vec_argmax(output int bi, output int bv);
    bi = 0;
    bv = q_elems[0];
    for (int i = 1; i < q_elems.size(); i++) begin
      if (q_elems[i] > bv) begin
        bv = q_elems[i];
        bi = i;
      end
    end
  endfunction

  task automatic model_step(input bit r, input bit v, input int d, input bit mr);
    int bi, bv;
    if (r) begin
      q_elems.delete();
      exp_pending = 0;
      exp_idx     = 0;
      exp_max     = 0;
    end else if (!exp_pending) begin
      if (v) begin
        q_elems.push_back(d);
        if (q_elems.size() == N) begin
          vec_argmax(bi, bv);
          exp_idx     = bi;
          exp_max     = bv;
          exp_pending = 1;
          q_elems.delete();
        end
      end
    end else if (mr) begin
      exp_pending = 0;
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare all outputs.
  task automatic cycle(input bit r, input bit v, input int d, input bit mr);
    elem_t dv;
    dv          = elem_t'(d);
    reset       = r;
    bus.s_valid = v;
    bus.data_in = dv;
    bus.m_ready = mr;
    @(posedge clk);
    model_step(r, v, int'(dv), mr);
    #1;
    check_eq("m_valid", int'(bus.m_valid), int'(exp_pending));
    check_eq("s_ready", int'(bus.s_ready), int'(!exp_pending));
    check_eq("idx_out", int'(bus.idx_out), exp_idx);
    check_eq("max_out", int'(bus.max_out), exp_max);
  endtask

  task automatic send_vec(input int v[8], input bit mr);
    for (int i = 0; i < 8; i++) cycle(0, 1, v[i], mr);
  endtask

  int vec[8];

  initial begin
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.data_in = '0;
    bus.m_ready = 1'b0;

    cycle(1, 0, 0, 0);
    cycle(1, 1, 1234, 1);
    check_eq("rst_sready", int'(bus.s_ready), 1);
    check_eq("rst_idx", int'(bus.idx_out), 0);
    check_eq("rst_max", int'(bus.max_out), 0);

    // Mixed values, duplicate max keeps lower index.
    vec = '{10, -5, 30, 7, 30, 2, 0, -1};
    send_vec(vec, 1);
    check_eq("s1_mvalid", int'(bus.m_valid), 1);
    check_eq("s1_idx", int'(bus.idx_out), 2);
    check_eq("s1_max", int'(bus.max_out), 30);
    cycle(0, 0, 0, 1);
    check_eq("s1_sready", int'(bus.s_ready), 1);

    // All most-negative.
    vec = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    send_vec(vec, 0);
    check_eq("s2_idx", int'(bus.idx_out), 0);
    check_eq("s2_max", int'(bus.max_out), -32768);
    cycle(0, 0, 0, 1);

    // Ascending with gaps.
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, i, 0);
      if (i != 8) cycle(0, 0, int'($urandom_range(0, 1000)), 0);
    end
    check_eq("s3_idx", int'(bus.idx_out), 7);
    check_eq("s3_max", int'(bus.max_out), 8);

    // Backpressure: result held, incoming data ignored.
    for (int i = 0; i < 5; i++) cycle(0, 1, int'($urandom_range(0, 65535)), 0);
    check_eq("s4_hold_idx", int'(bus.idx_out), 7);
    check_eq("s4_hold_max", int'(bus.max_out), 8);
    cycle(0, 0, 0, 1);
    check_eq("s4_rel_mvalid", int'(bus.m_valid), 0);
    check_eq("s4_rel_sready", int'(bus.s_ready), 1);

    // Partial vector with a large value, then reset.
    cycle(0, 1, 1, 0);
    cycle(0, 1, 2, 0);
    cycle(0, 1, 3, 0);
    cycle(0, 1, 99, 0);
    cycle(1, 1, 500, 1);
    vec = '{5, 4, 3, 2, 1, 0, -1, -2};
    send_vec(vec, 0);
    check_eq("s5_idx", int'(bus.idx_out), 0);
    check_eq("s5_max", int'(bus.max_out), 5);

    // Reset while a result is pending.
    cycle(1, 0, 0, 0);
    check_eq("s5b_mvalid", int'(bus.m_valid), 0);

    // Two vectors back to back; first result stays until its handshake.
    vec = '{-7, 300, 12, 300, -1, 45, 299, 0};
    send_vec(vec, 0);
    cycle(0, 1, 9999, 0);
    cycle(0, 1, 9999, 0);
    check_eq("s6_first_idx", int'(bus.idx_out), 1);
    check_eq("s6_first_max", int'(bus.max_out), 300);
    cycle(0, 0, 0, 1);
    vec = '{0, 0, 0, 0, 0, 0, 1, 0};
    send_vec(vec, 0);
    check_eq("s6_second_idx", int'(bus.idx_out), 6);
    check_eq("s6_second_max", int'(bus.max_out), 1);
    cycle(0, 0, 0, 1);

    // Random traffic, narrow value range at times to provoke ties.
    for (int i = 0; i < 600; i++) begin
      bit r, v, mr;
      int d;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      if (i < 300) d = int'($urandom_range(0, 65535)) - 32768;
      else         d = int'($urandom_range(0, 6)) - 3;
      cycle(r, v, d, mr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
